riscv_data_memory: RTL

RISCV_DATA_MEMORY -- requirements
Module: riscv_data_memory

---
 rtl/riscv_data_memory_if.sv | 24 ++
 rtl/riscv_data_memory.sv | 101 ++++++++++
 2 files changed

// File: rtl/riscv_data_memory_if.sv
// Load/store bus between a RISC-V core (master) and its data memory (slave).
// Signal names match the core's existing memory-port names.
interface riscv_data_memory_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] dAddress;
  logic [XLEN-1:0] dWriteData;
  logic            MemRead;
  logic            MemWrite;
  logic [XLEN-1:0] dReadData;
  logic            readValid;
  logic            accessError;
  logic [15:0]     leds;

  modport master (
    output dAddress, dWriteData, MemRead, MemWrite,
    input  dReadData, readValid, accessError, leds
  );

  modport slave (
    input  dAddress, dWriteData, MemRead, MemWrite,
    output dReadData, readValid, accessError, leds
  );
endinterface

// File: rtl/riscv_data_memory.sv
// Data memory for a RISC-V core: word RAM, LED register and free-running
// cycle counter, with one-cycle registered loads and alignment/decode faults.
module riscv_data_memory #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] DATA_BASE   = 32'h1001_0000,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] IO_BASE     = 32'hFFFF_0000
) (
  input  logic                clk,
  input  logic                rst,
  riscv_data_memory_if.slave  bus
);

  localparam int              AW        = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(4 * DEPTH_WORDS);
  localparam logic [XLEN-1:0] LED_ADDR  = IO_BASE;
  localparam logic [XLEN-1:0] CNT_ADDR  = IO_BASE + XLEN'(4);

  // Source of dReadData for the current load result.
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_IO   = 2'd2;

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] ram_q;
  logic [XLEN-1:0] io_q;
  logic [1:0]      sel;
  logic [31:0]     cycle_count;
  logic [15:0]     led_reg;
  logic            read_valid_q;
  logic            access_error_q;

  logic [XLEN-1:0] offset;
  logic [AW-1:0]   word_idx;
  logic            ram_hit, led_hit, cnt_hit, misaligned, request, fault;
  logic            ram_we, ram_re, led_we, io_re;

  // Subtracting first makes addresses below DATA_BASE wrap to huge offsets,
  // so one unsigned compare covers both bounds.
  assign offset     = bus.dAddress - DATA_BASE;
  assign word_idx   = offset[AW+1:2];
  assign ram_hit    = offset < RAM_BYTES;
  assign led_hit    = bus.dAddress == LED_ADDR;
  assign cnt_hit    = bus.dAddress == CNT_ADDR;
  assign misaligned = bus.dAddress[1:0] != 2'b00;
  assign request    = bus.MemRead | bus.MemWrite;

  assign fault = misaligned
               | !(ram_hit | led_hit | cnt_hit)
               | (bus.MemWrite & cnt_hit);

  assign ram_we = !rst & bus.MemWrite & !fault & ram_hit;
  assign ram_re = !rst & bus.MemRead  & !fault & ram_hit;
  assign led_we = !rst & bus.MemWrite & !fault & led_hit;
  assign io_re  = !rst & bus.MemRead  & !fault & (led_hit | cnt_hit);

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents
  // survive rst. Read and write share one port, and the non-blocking read
  // of mem[] returns the old word on a same-edge write (read-first).
  always_ff @(posedge clk) begin
    if (ram_we) mem[word_idx] <= bus.dWriteData;
    if (ram_re) ram_q <= mem[word_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel            <= SEL_ZERO;
      io_q           <= '0;
      read_valid_q   <= 1'b0;
      access_error_q <= 1'b0;
      led_reg        <= '0;
      cycle_count    <= '0;
    end else begin
      cycle_count    <= cycle_count + 32'd1;
      read_valid_q   <= bus.MemRead;
      access_error_q <= request & fault;
      if (led_we) led_reg <= bus.dWriteData[15:0];
      if (io_re)  io_q    <= led_hit ? XLEN'(led_reg) : XLEN'(cycle_count);
      // sel only moves on a load so dReadData holds between loads.
      if (bus.MemRead) begin
        if (fault)        sel <= SEL_ZERO;
        else if (ram_hit) sel <= SEL_RAM;
        else              sel <= SEL_IO;
      end
    end
  end

  always_comb begin
    bus.dReadData = '0;
    case (sel)
      SEL_RAM: bus.dReadData = ram_q;
      SEL_IO:  bus.dReadData = io_q;
      default: bus.dReadData = '0;
    endcase
  end

  assign bus.readValid   = read_valid_q;
  assign bus.accessError = access_error_q;
  assign bus.leds        = led_reg;

endmodule
